// File: rtl/pixel_scan_ctrl.sv
// pixel_scan_ctrl: raster-timing controller.
// It paces a producer pixel stream against a fixed H/V scan and emits one
// registered pixel per active cycle to the display sink. On producer
// underflow it substitutes FILL_COLOR and counts the event.
// Optional feature: define PIXEL_SCAN_FRAME_CRC_EN to enable the per-frame
// CRC-16-CCITT on frame_crc_o. When it is undefined, frame_crc_o is tied to 0.
module pixel_scan_ctrl #(
    parameter int unsigned H_ACTIVE   = 64,
    parameter int unsigned H_BLANK    = 8,
    parameter int unsigned V_ACTIVE   = 32,
    parameter int unsigned V_BLANK    = 4,
    parameter logic [23:0] FILL_COLOR = 24'hFF00FF
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        en_i,
    input  logic                        pixel_valid_i,
    input  logic [23:0]                 pixel_data_i,
    output logic                        pixel_ready_o,
    output logic                        frame_idx_o,
    output logic                        disp_valid_o,
    output logic [23:0]                 disp_data_o,
    output logic [$clog2(H_ACTIVE)-1:0] disp_x_o,
    output logic [$clog2(V_ACTIVE)-1:0] disp_y_o,
    output logic                        vblank_o,
    output logic                        underflow_o,
    output logic [15:0]                 underflow_cnt_o,
    input  logic                        clr_i,
    output logic [15:0]                 frame_crc_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_BLANK;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned XW      = $clog2(H_ACTIVE);
    localparam int unsigned YW      = $clog2(V_ACTIVE);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          running;
    logic          active;
    logic          h_last;
    logic          v_last;
    logic          frame_end;
    logic          uf_event;

    assign running   = (state == RUN);
    assign h_last    = (h == HW'(H_TOTAL - 1));
    assign v_last    = (v == VW'(V_TOTAL - 1));
    assign active    = running && (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
    // End of the last active line: the frame_idx toggle point
    assign frame_end = running && h_last && (v == VW'(V_ACTIVE - 1));
    assign uf_event  = active && !pixel_valid_i;

    // Ready is a pure decode of the scan position, independent of valid
    assign pixel_ready_o = active;

    // Scan FSM with H/V counters; en_i is only honoured at the frame wrap
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            h     <= '0;
            v     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    h <= '0;
                    v <= '0;
                    if (en_i) state <= RUN;
                end
                RUN: begin
                    if (h_last) begin
                        h <= '0;
                        if (v_last) begin
                            v <= '0;
                            if (!en_i) state <= IDLE;
                        end else begin
                            v <= v + VW'(1);
                        end
                    end else begin
                        h <= h + HW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Display-side pixel, position, blanking and frame index, one cycle behind the scan
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            disp_valid_o <= 1'b0;
            disp_data_o  <= '0;
            disp_x_o     <= '0;
            disp_y_o     <= '0;
            vblank_o     <= 1'b0;
            frame_idx_o  <= 1'b0;
        end else begin
            disp_valid_o <= active;
            vblank_o     <= running && (v >= VW'(V_ACTIVE));
            if (active) begin
                disp_data_o <= pixel_valid_i ? pixel_data_i : FILL_COLOR;
                disp_x_o    <= XW'(h);
                disp_y_o    <= YW'(v);
            end
            if (frame_end) frame_idx_o <= ~frame_idx_o;
        end
    end

    // Sticky underflow flag and saturating counter; a same-cycle event wins over clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            underflow_o     <= 1'b0;
            underflow_cnt_o <= '0;
        end else if (uf_event) begin
            underflow_o <= 1'b1;
            if (clr_i)
                underflow_cnt_o <= 16'd1;
            else if (underflow_cnt_o != 16'hFFFF)
                underflow_cnt_o <= underflow_cnt_o + 16'd1;
        end else if (clr_i) begin
            underflow_o     <= 1'b0;
            underflow_cnt_o <= '0;
        end
    end

`ifdef PIXEL_SCAN_FRAME_CRC_EN
    // One 24-bit CRC-16-CCITT step, MSB first
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [23:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 23; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    logic [15:0] crc_run;

    // Running CRC over emitted pixels, latched and reseeded at each frame_idx toggle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            crc_run     <= 16'hFFFF;
            frame_crc_o <= '0;
        end else if (frame_end) begin
            frame_crc_o <= crc_run;
            crc_run     <= 16'hFFFF;
        end else if (disp_valid_o) begin
            crc_run <= crc_step(crc_run, disp_data_o);
        end
    end
`else
    assign frame_crc_o = '0;
`endif

endmodule

// File: doc/pixel_scan_ctrl.md
Name: pixel_scan_ctrl

Overview:
- Raster-timing controller for the SoC pixel stream.
- Paces the producer's pixel_valid/pixel_ready/pixel_data stream against a fixed H/V scan and drives frame_idx back to the producer.
- Emits one registered pixel per active-region cycle, with x/y, to the display-side sink.
- Substitutes a fill colour on producer underflow and counts those events.

Parameters:
H_ACTIVE, 64, active pixels per line
H_BLANK, 8, blanking cycles per line
V_ACTIVE, 32, active lines per frame
V_BLANK, 4, blanking lines per frame
FILL_COLOR, 24'hFF00FF, pixel emitted on underflow

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
en_i  in  1  scan enable, sampled only at frame boundary
pixel_valid_i  in  1  producer pixel valid
pixel_data_i  in  24  producer pixel, RGB888
pixel_ready_o  out  1  pixel accepted this cycle when valid
frame_idx_o  out  1  toggles once per frame
disp_valid_o  out  1  display pixel strobe
disp_data_o  out  24  display pixel
disp_x_o  out  $clog2(H_ACTIVE)  column of disp_data_o
disp_y_o  out  $clog2(V_ACTIVE)  row of disp_data_o
vblank_o  out  1  v counter in blanking lines
underflow_o  out  1  sticky underflow flag
underflow_cnt_o  out  16  underflow count, saturating
clr_i  in  1  clears underflow_o and underflow_cnt_o
frame_crc_o  out  16  last-frame CRC (optional feature)

Behaviour:
- Derived totals:
  - H_TOTAL = H_ACTIVE + H_BLANK.
  - V_TOTAL = V_ACTIVE + V_BLANK.
- Reset state (rst_i high, async): all outputs 0, state IDLE, h = v = 0.
- States:
  - IDLE: h = v = 0, pixel_ready_o = 0, disp_valid_o = 0.
    - en_i = 1 moves to RUN next cycle; the first RUN cycle has h = 0, v = 0.
  - RUN:
    - h increments each cycle and wraps at H_TOTAL-1 to 0.
    - v increments on each h wrap and wraps at V_TOTAL-1 to 0.
    - At the frame wrap (h = H_TOTAL-1, v = V_TOTAL-1): if en_i = 0, go to IDLE; otherwise continue from 0,0.
    - en_i deassertion mid-frame is ignored; the frame always completes.
- Active cycle: state RUN and h < H_ACTIVE and v < V_ACTIVE.
- pixel_ready_o = active. It is a combinational decode of registered state only, with no dependence on pixel_valid_i.
- Transfer: pixel_valid_i & pixel_ready_o.
- Display output, 1-cycle latency, registered:
  - disp_valid_o <= active.
  - disp_data_o <= pixel_valid_i ? pixel_data_i : FILL_COLOR.
  - disp_x_o <= h, disp_y_o <= v, captured in active cycles only; they hold otherwise.
- Underflow event: active & !pixel_valid_i.
  - Sets underflow_o.
  - underflow_cnt_o += 1, saturating at 16'hFFFF.
  - If clr_i and an event occur in the same cycle, the result is flag = 1 and count = 1.
- frame_idx_o toggles on the cycle after h = H_TOTAL-1, v = V_ACTIVE-1 (end of last active line) in RUN.
- vblank_o <= (v >= V_ACTIVE) in RUN, registered.
- Producer valid outside the active region: ignored, nothing consumed.
- rst_i asserted mid-frame: immediate return to the reset state. frame_idx_o and underflow state are cleared.

Optional Feature:
- Macro: PIXEL_SCAN_FRAME_CRC_EN.
- Defined:
  - A CRC-16-CCITT (poly 0x1021, init 0xFFFF) runs over the 24-bit disp_data_o of every disp_valid_o cycle, MSB byte first, one 24-bit step per cycle.
  - At the frame_idx_o toggle, the final value is latched into frame_crc_o and the running CRC reinitialises to 0xFFFF.
- Undefined: frame_crc_o is constant 0 and no CRC logic is instantiated.

Test Plan:
All scenarios use H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, V_BLANK=1 (24-cycle frame, 12 active pixels).
- Reset, en_i = 0 for 10 cycles -> all outputs 0, pixel_ready_o never high.
- en_i = 1, producer always valid with data = 24'h000000 + index -> exactly 12 transfers per frame, disp pixels 0..11 with x/y (0,0)..(3,2), disp_valid_o lagging pixel_ready_o by 1 cycle, frame_idx_o toggling every 24 cycles.
- Producer withholds valid on pixel (2,1) -> disp_data_o = 24'hFF00FF at x=2, y=1; underflow_o = 1; underflow_cnt_o = 1. Asserting clr_i then gives 0/0.
- en_i dropped at cycle 5 of a frame -> frame finishes (12 pixels total), then IDLE with pixel_ready_o = 0. Re-asserting en_i restarts at (0,0).
- rst_i pulsed at h=2, v=1 -> outputs clear asynchronously. Scan restarts at (0,0) after rst_i falls with en_i = 1.
- CRC enabled, all pixels 24'h000000 -> frame_crc_o equals the reference-model CRC of 12 zero pixels after the first toggle, and is identical every frame.
